vga_pattern_gen: RTL and testbench

Parametrised multi-mode VGA test-pattern source that drives the colour inputs of vga_sync from its px/py coordinates. It generalises the switch-selected colour-bar/gray-ramp generator with configurable colour width, resolution and bar count. It adds frame-synchronous mode switching, a frame counter and an animated bouncing box. Outputs are registered with 1-cycle latency.

---
 rtl/vga_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern source: bars, gray ramp, checkerboard and a bouncing box.
// Optional 1-pixel white frame border when PATTERN_BORDER_EN is defined.
module vga_pattern_gen #(
  parameter int unsigned COLOR_W    = 10,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned BAR_COUNT  = 8,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned BOX_SIZE   = 32,
  parameter int unsigned STEP       = 2
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [2:0]         iMode,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic [COLOR_W-1:0] oRed,
  output logic [COLOR_W-1:0] oGreen,
  output logic [COLOR_W-1:0] oBlue,
  output logic [2:0]         oMode,
  output logic [15:0]        oFrameCnt
);

  localparam int unsigned AW    = COORD_W + COLOR_W + 1;
  localparam int unsigned BAR_W = H_ACTIVE / BAR_COUNT;

  localparam logic [AW-1:0] H_A     = AW'(H_ACTIVE);
  localparam logic [AW-1:0] V_A     = AW'(V_ACTIVE);
  localparam logic [AW-1:0] BAR_W_A = AW'(BAR_W);
  localparam logic [AW-1:0] BAR_MAX = AW'(BAR_COUNT - 1);
  localparam logic [AW-1:0] BOX_A   = AW'(BOX_SIZE);
  localparam logic [AW-1:0] STEP_A  = AW'(STEP);

  localparam logic [2:0] MODE_BLACK   = 3'd0;
  localparam logic [2:0] MODE_BARS    = 3'd1;
  localparam logic [2:0] MODE_GRAY    = 3'd2;
  localparam logic [2:0] MODE_CHECKER = 3'd3;
  localparam logic [2:0] MODE_BOX     = 3'd4;

  localparam logic [COLOR_W-1:0] FULL = '1;
  localparam logic [COLOR_W-1:0] HALF = {1'b1, {(COLOR_W-1){1'b0}}};

  logic               origin_q;
  logic [COORD_W-1:0] bx, by;
  logic               dx_neg, dy_neg;

  logic               at_origin_c, fs_c;
  logic [COORD_W-1:0] bx_next_c, by_next_c;
  logic               dx_neg_next_c, dy_neg_next_c;

  logic [AW-1:0]      x_a, y_a, bx_a, by_a;
  logic               active_c, checker_c, in_box_c;
  logic [AW-1:0]      bar_div_c, gray_full_c;
  logic [2:0]         bar_code_c;
  logic [COLOR_W-1:0] gray_c;
  logic [COLOR_W-1:0] red_c, green_c, blue_c;

  // Frame start: first cycle at the origin; a held origin yields one pulse.
  assign at_origin_c = (px == '0) && (py == '0);
  assign fs_c        = at_origin_c && !origin_q;

  // One axis of box motion: returns {negative_direction, new_position}.
  function automatic logic [COORD_W:0] step_axis(input logic [COORD_W-1:0] pos,
                                                 input logic               neg,
                                                 input logic [AW-1:0]      limit);
    logic [AW-1:0] p;
    logic [COORD_W:0] res;
    p = AW'(pos);
    if (!neg) begin
      if (p + STEP_A + BOX_A >= limit) res = {1'b1, COORD_W'(limit - BOX_A)};
      else                             res = {1'b0, COORD_W'(p + STEP_A)};
    end else begin
      if (p <= STEP_A) res = {1'b0, {COORD_W{1'b0}}};
      else             res = {1'b1, COORD_W'(p - STEP_A)};
    end
    return res;
  endfunction

  assign {dx_neg_next_c, bx_next_c} = step_axis(bx, dx_neg, H_A);
  assign {dy_neg_next_c, by_next_c} = step_axis(by, dy_neg, V_A);

  // Coordinate math carried in AW bits so shifts and sums cannot overflow.
  assign x_a      = AW'(px);
  assign y_a      = AW'(py);
  assign bx_a     = AW'(bx);
  assign by_a     = AW'(by);
  assign active_c = (x_a < H_A) && (y_a < V_A);

  assign bar_div_c   = x_a / BAR_W_A;
  assign bar_code_c  = 3'(3'd7 - ((bar_div_c > BAR_MAX) ? 3'(BAR_MAX) : 3'(bar_div_c)));
  assign gray_full_c = (x_a << COLOR_W) / H_A;
  assign gray_c      = COLOR_W'(gray_full_c);
  assign checker_c   = px[CHECK_LOG2] ^ py[CHECK_LOG2];
  assign in_box_c    = (x_a >= bx_a) && (x_a < bx_a + BOX_A) &&
                       (y_a >= by_a) && (y_a < by_a + BOX_A);

  // Pixel colour from the mode in effect and the pre-update box position.
  always_comb begin
    red_c   = '0;
    green_c = '0;
    blue_c  = '0;
    if (active_c) begin
      case (oMode)
        MODE_BARS: begin
          red_c   = bar_code_c[2] ? FULL : '0;
          green_c = bar_code_c[1] ? FULL : '0;
          blue_c  = bar_code_c[0] ? FULL : '0;
        end
        MODE_GRAY: begin
          red_c   = gray_c;
          green_c = gray_c;
          blue_c  = gray_c;
        end
        MODE_CHECKER: begin
          red_c   = checker_c ? FULL : '0;
          green_c = checker_c ? FULL : '0;
          blue_c  = checker_c ? FULL : '0;
        end
        MODE_BOX: begin
          red_c   = in_box_c ? FULL : '0;
          green_c = in_box_c ? FULL : '0;
          blue_c  = in_box_c ? FULL : HALF;
        end
        default: begin
          red_c   = '0;
          green_c = '0;
          blue_c  = '0;
        end
      endcase
`ifdef PATTERN_BORDER_EN
      if ((oMode != MODE_BLACK) &&
          ((x_a == '0) || (x_a == H_A - AW'(1)) || (y_a == '0) || (y_a == V_A - AW'(1)))) begin
        red_c   = FULL;
        green_c = FULL;
        blue_c  = FULL;
      end
`endif
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oRed      <= '0;
      oGreen    <= '0;
      oBlue     <= '0;
      oMode     <= '0;
      oFrameCnt <= '0;
      origin_q  <= 1'b0;
      bx        <= '0;
      by        <= '0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
    end else begin
      oRed     <= red_c;
      oGreen   <= green_c;
      oBlue    <= blue_c;
      origin_q <= at_origin_c;
      if (fs_c) begin
        oMode     <= iMode;
        oFrameCnt <= oFrameCnt + 16'd1;
        bx        <= bx_next_c;
        by        <= by_next_c;
        dx_neg    <= dx_neg_next_c;
        dy_neg    <= dy_neg_next_c;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: vector table plus multi-frame sequences.
module tb_vga_pattern_gen;

  localparam logic [9:0] F = 10'h3FF;
  localparam logic [9:0] H = 10'h200;
`ifdef PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [2:0] iMode;
  logic [9:0] px, py;
  logic [9:0] oRed, oGreen, oBlue;
  logic [2:0] oMode;
  logic [15:0] oFrameCnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_fc   = 16'd0;
  logic [2:0]  exp_mode = 3'd0;

  always #5 iCLK = ~iCLK;

  vga_pattern_gen dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iMode     (iMode),
    .px        (px),
    .py        (py),
    .oRed      (oRed),
    .oGreen    (oGreen),
    .oBlue     (oBlue),
    .oMode     (oMode),
    .oFrameCnt (oFrameCnt)
  );

  typedef struct {
    logic [2:0] mode;
    int         x;
    int         y;
    logic       on_border;
    logic [9:0] r, g, b;
  } vec_t;

  vec_t vecs [0:19];

  task automatic cyc(input int x, input int y);
    px = 10'(x);
    py = 10'(y);
    @(posedge iCLK);
    #1;
  endtask

  task automatic frame(input logic [2:0] m);
    iMode = m;
    cyc(1, 0);
    cyc(0, 0);
    exp_fc   = exp_fc + 16'd1;
    exp_mode = m;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rgb(input string name, input logic [9:0] r, input logic [9:0] g,
                         input logic [9:0] b);
    chk({name, ".r"}, int'(oRed), int'(r));
    chk({name, ".g"}, int'(oGreen), int'(g));
    chk({name, ".b"}, int'(oBlue), int'(b));
  endtask

  task automatic chk_state(input string name);
    chk({name, ".mode"}, int'(oMode), int'(exp_mode));
    chk({name, ".fcnt"}, int'(oFrameCnt), int'(exp_fc));
  endtask

  task automatic pix(input string name, input int x, input int y,
                     input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    cyc(x, y);
    chk_rgb(name, r, g, b);
  endtask

  initial begin
    logic [9:0] er, eg, eb;

    vecs[0]  = '{3'd1,  85,  10, 1'b0, F, F, 10'h0};
    vecs[1]  = '{3'd1, 639,  10, 1'b1, 10'h0, 10'h0, 10'h0};
    vecs[2]  = '{3'd1, 700,  10, 1'b0, 10'h0, 10'h0, 10'h0};
    vecs[3]  = '{3'd1,   0,  10, 1'b1, F, F, F};
    vecs[4]  = '{3'd1, 160, 100, 1'b0, F, 10'h0, F};
    vecs[5]  = '{3'd1, 400, 100, 1'b0, 10'h0, F, 10'h0};
    vecs[6]  = '{3'd1, 100, 480, 1'b0, 10'h0, 10'h0, 10'h0};
    vecs[7]  = '{3'd2, 320,  10, 1'b0, H, H, H};
    vecs[8]  = '{3'd2,   0,  10, 1'b1, 10'h0, 10'h0, 10'h0};
    vecs[9]  = '{3'd2, 639,  10, 1'b1, 10'h3FE, 10'h3FE, 10'h3FE};
    vecs[10] = '{3'd2, 160,  10, 1'b0, 10'h100, 10'h100, 10'h100};
    vecs[11] = '{3'd3,   0,  10, 1'b1, 10'h0, 10'h0, 10'h0};
    vecs[12] = '{3'd3,  32,  10, 1'b0, F, F, F};
    vecs[13] = '{3'd3,  32,  32, 1'b0, 10'h0, 10'h0, 10'h0};
    vecs[14] = '{3'd3,  10,  40, 1'b0, F, F, F};
    vecs[15] = '{3'd0, 100, 100, 1'b0, 10'h0, 10'h0, 10'h0};
    vecs[16] = '{3'd0,   0,  50, 1'b1, 10'h0, 10'h0, 10'h0};
    vecs[17] = '{3'd5, 100, 100, 1'b0, 10'h0, 10'h0, 10'h0};
    vecs[18] = '{3'd7, 200, 200, 1'b0, 10'h0, 10'h0, 10'h0};
    vecs[19] = '{3'd2,   0,  50, 1'b1, 10'h0, 10'h0, 10'h0};

    iRST_N = 1'b0;
    iMode  = 3'd1;
    px     = '0;
    py     = '0;

    // Reset held with coordinates sweeping through the origin.
    cyc(0, 0);  chk_rgb("rst0", 0, 0, 0); chk_state("rst0");
    cyc(5, 7);  chk_rgb("rst1", 0, 0, 0); chk_state("rst1");
    cyc(0, 0);  chk_rgb("rst2", 0, 0, 0); chk_state("rst2");
    iRST_N = 1'b1;
    cyc(3, 3);
    frame(3'd1);
    chk_state("first_fs");

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].mode != exp_mode) frame(vecs[i].mode);
      cyc(vecs[i].x, vecs[i].y);
      er = vecs[i].r;
      eg = vecs[i].g;
      eb = vecs[i].b;
      if (BORDER && vecs[i].on_border && vecs[i].mode != 3'd0) begin
        er = F; eg = F; eb = F;
      end
      chk_rgb($sformatf("vec%0d", i), er, eg, eb);
      chk($sformatf("vec%0d.mode", i), int'(oMode), int'(vecs[i].mode));
    end

    // Mode request mid-frame is deferred to the next frame start.
    frame(3'd1);
    iMode = 3'd3;
    pix("midframe", 100, 200, F, F, 10'h0);
    chk_state("midframe");
    cyc(0, 0);
    exp_fc   = exp_fc + 16'd1;
    exp_mode = 3'd3;
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk_state("held_origin");
    chk_rgb("held_origin", BORDER ? F : 10'h0, BORDER ? F : 10'h0, BORDER ? F : 10'h0);

    // Reset mid-frame, then bouncing-box trajectory from a fresh start.
    iMode = 3'd4;
    cyc(300, 300);
    iRST_N   = 1'b0;
    exp_fc   = 16'd0;
    exp_mode = 3'd0;
    cyc(50, 60);
    chk_rgb("rst_mid", 0, 0, 0);
    chk_state("rst_mid");
    iRST_N = 1'b1;
    cyc(5, 5);

    frame(3'd4);
    chk_state("box_f1");
    pix("box_f1_in",    2,  2, F, F, F);
    pix("box_f1_left",  1,  2, 10'h0, 10'h0, H);
    pix("box_f1_far",  33, 33, F, F, F);
    pix("box_f1_out",  34,  2, 10'h0, 10'h0, H);

    for (int i = 2; i <= 224; i++) frame(3'd4);
    chk_state("box_f224");
    pix("box_f224_top",   448, 448, F, F, F);
    pix("box_f224_above", 448, 447, 10'h0, 10'h0, H);
    pix("box_f224_bot",   448, 479, F, F, F);

    frame(3'd4);
    pix("box_f225_top",   450, 446, F, F, F);
    pix("box_f225_above", 450, 445, 10'h0, 10'h0, H);
    pix("box_f225_bot",   450, 477, F, F, F);
    pix("box_f225_below", 450, 478, 10'h0, 10'h0, H);

    for (int i = 226; i <= 304; i++) frame(3'd4);
    chk_state("box_f304");
    pix("box_f304_left",  608, 288, F, F, F);
    pix("box_f304_out",   607, 288, 10'h0, 10'h0, H);
    pix("box_f304_right", 639, 288, F, F, F);
    pix("box_f304_bot",   608, 319, F, F, F);
    pix("box_f304_below", 608, 320, 10'h0, 10'h0, H);

    frame(3'd4);
    pix("box_f305_left",  606, 286, F, F, F);
    pix("box_f305_right", 637, 286, F, F, F);
    pix("box_f305_out",   638, 286, 10'h0, 10'h0, H);
    chk_state("box_f305");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
